// File: rtl/vga_axil_slave_if.sv
// vga_axil_slave_if: AXI4-Lite channel bundle between the SoC interconnect and the vga_top bridge
// Signals: aw*/w*/b* write address, data and response channels; ar*/r* read address and data
//   channels. The master modport drives valids, addresses, data and response readies.
//   The slave modport drives address/data readies, responses and read data.
interface vga_axil_slave_if #(
    parameter int AW = 15,
    parameter int DW = 32
);
    logic            awvalid;
    logic            awready;
    logic [AW+1:0]   awaddr;
    logic            wvalid;
    logic            wready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            bvalid;
    logic            bready;
    logic [1:0]      bresp;
    logic            arvalid;
    logic            arready;
    logic [AW+1:0]   araddr;
    logic            rvalid;
    logic            rready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/vga_axil_slave.sv
// vga_axil_slave: AXI4-Lite slave that turns each AXI transaction into a vga_top strobe
// Ports: clk_i system clock; rstn_i asynchronous active-low reset; s_axi AXI4-Lite slave
//   channels; axil_wready_o/axil_waddr_o/axil_wdata_o/axil_wstrb_o one-cycle write strobe
//   to vga_top; axil_rreq_o/axil_raddr_o one-cycle read request; axil_rdata_i read data
//   valid RD_LATENCY cycles after the request.
module vga_axil_slave #(
    parameter int C_AXI_ADDR_WIDTH = 15,
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int RD_LATENCY       = 1
) (
    input  logic                            clk_i,
    input  logic                            rstn_i,
    vga_axil_slave_if.slave                 s_axi,
    output logic [C_AXI_DATA_WIDTH-1:0]     axil_wdata_o,
    output logic [C_AXI_DATA_WIDTH/8-1:0]   axil_wstrb_o,
    output logic [C_AXI_ADDR_WIDTH-1:0]     axil_waddr_o,
    output logic                            axil_wready_o,
    output logic                            axil_rreq_o,
    output logic [C_AXI_ADDR_WIDTH-1:0]     axil_raddr_o,
    input  logic [C_AXI_DATA_WIDTH-1:0]     axil_rdata_i
);
    localparam int AW = C_AXI_ADDR_WIDTH;
    localparam int DW = C_AXI_DATA_WIDTH;
    localparam int SW = DW / 8;
    localparam int CW = RD_LATENCY > 1 ? $clog2(RD_LATENCY) : 1;
    localparam logic [CW-1:0] LAST = CW'(RD_LATENCY - 1);

    localparam logic [1:0] W_IDLE   = 2'd0;
    localparam logic [1:0] W_STROBE = 2'd1;
    localparam logic [1:0] W_RESP   = 2'd2;
    localparam logic [1:0] R_IDLE   = 2'd0;
    localparam logic [1:0] R_REQ    = 2'd1;
    localparam logic [1:0] R_WAIT   = 2'd2;
    localparam logic [1:0] R_RESP   = 2'd3;

    logic [1:0]    w_state;
    logic [1:0]    r_state;
    logic          aw_held;
    logic          w_held;
    logic [AW-1:0] awaddr_q;
    logic [DW-1:0] wdata_q;
    logic [SW-1:0] wstrb_q;
    logic [CW-1:0] cnt;
    logic          aw_hs;
    logic          w_hs;
    logic          ar_hs;
    logic          aw_got;
    logic          w_got;
    logic          unused_addr_bits;

    assign aw_hs  = s_axi.awvalid & s_axi.awready;
    assign w_hs   = s_axi.wvalid & s_axi.wready;
    assign ar_hs  = s_axi.arvalid & s_axi.arready;
    assign aw_got = aw_held | aw_hs;
    assign w_got  = w_held | w_hs;
    assign s_axi.bresp = 2'b00;
    assign s_axi.rresp = 2'b00;
    assign unused_addr_bits = ^{s_axi.awaddr[1:0], s_axi.araddr[1:0]};

    // AW and W are collected independently; the strobe fires once both are in hand,
    // taking the just-handshaken value directly when it arrives in the final cycle.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            w_state        <= W_IDLE;
            aw_held        <= 1'b0;
            w_held         <= 1'b0;
            awaddr_q       <= '0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
            s_axi.awready  <= 1'b0;
            s_axi.wready   <= 1'b0;
            s_axi.bvalid   <= 1'b0;
            axil_wready_o  <= 1'b0;
            axil_waddr_o   <= '0;
            axil_wdata_o   <= '0;
            axil_wstrb_o   <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) awaddr_q <= s_axi.awaddr[AW+1:2];
                    if (w_hs) begin
                        wdata_q <= s_axi.wdata;
                        wstrb_q <= s_axi.wstrb;
                    end
                    if (aw_got && w_got) begin
                        w_state       <= W_STROBE;
                        axil_wready_o <= 1'b1;
                        axil_waddr_o  <= aw_hs ? s_axi.awaddr[AW+1:2] : awaddr_q;
                        axil_wdata_o  <= w_hs ? s_axi.wdata : wdata_q;
                        axil_wstrb_o  <= w_hs ? s_axi.wstrb : wstrb_q;
                        aw_held       <= 1'b0;
                        w_held        <= 1'b0;
                        s_axi.awready <= 1'b0;
                        s_axi.wready  <= 1'b0;
                    end else begin
                        aw_held       <= aw_got;
                        w_held        <= w_got;
                        s_axi.awready <= ~aw_got;
                        s_axi.wready  <= ~w_got;
                    end
                end
                W_STROBE: begin
                    axil_wready_o <= 1'b0;
                    s_axi.bvalid  <= 1'b1;
                    w_state       <= W_RESP;
                end
                default: begin
                    if (s_axi.bready) begin
                        s_axi.bvalid  <= 1'b0;
                        s_axi.awready <= 1'b1;
                        s_axi.wready  <= 1'b1;
                        w_state       <= W_IDLE;
                    end
                end
            endcase
        end
    end

    // cnt spans the RD_LATENCY wait cycles so axil_rdata_i is sampled exactly when valid.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state       <= R_IDLE;
            cnt           <= '0;
            s_axi.arready <= 1'b0;
            s_axi.rvalid  <= 1'b0;
            s_axi.rdata   <= '0;
            axil_rreq_o   <= 1'b0;
            axil_raddr_o  <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        s_axi.arready <= 1'b0;
                        axil_raddr_o  <= s_axi.araddr[AW+1:2];
                        axil_rreq_o   <= 1'b1;
                        r_state       <= R_REQ;
                    end else begin
                        s_axi.arready <= 1'b1;
                    end
                end
                R_REQ: begin
                    axil_rreq_o <= 1'b0;
                    cnt         <= '0;
                    r_state     <= R_WAIT;
                end
                R_WAIT: begin
                    if (cnt == LAST) begin
                        s_axi.rdata  <= axil_rdata_i;
                        s_axi.rvalid <= 1'b1;
                        r_state      <= R_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (s_axi.rready) begin
                        s_axi.rvalid  <= 1'b0;
                        s_axi.arready <= 1'b1;
                        r_state       <= R_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vga_axil_slave.sv
// tb_vga_axil_slave: directed and randomized checks of the AXI4-Lite to vga_top bridge
module tb_vga_axil_slave;
    localparam int RD_LAT = 1;

    typedef struct packed {int c; logic [14:0] a; logic [31:0] d; logic [3:0] s;} st_t;
    typedef struct packed {int c; logic [14:0] a;} rq_t;

    logic        clk_i;
    logic        rstn_i;
    logic [31:0] axil_wdata_o;
    logic [3:0]  axil_wstrb_o;
    logic [14:0] axil_waddr_o;
    logic        axil_wready_o;
    logic        axil_rreq_o;
    logic [14:0] axil_raddr_o;
    logic [31:0] axil_rdata_i;

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    st_t st_q[$];
    rq_t rq_q[$];
    logic [31:0] vmem [int];
    logic [31:0] mm [int];
    int rd_cnt = 0;
    logic [14:0] rd_a;

    vga_axil_slave_if #(.AW(15), .DW(32)) ax();

    vga_axil_slave #(
        .C_AXI_ADDR_WIDTH(15),
        .C_AXI_DATA_WIDTH(32),
        .RD_LATENCY(RD_LAT)
    ) dut (
        .clk_i(clk_i),
        .rstn_i(rstn_i),
        .s_axi(ax),
        .axil_wdata_o(axil_wdata_o),
        .axil_wstrb_o(axil_wstrb_o),
        .axil_waddr_o(axil_waddr_o),
        .axil_wready_o(axil_wready_o),
        .axil_rreq_o(axil_rreq_o),
        .axil_raddr_o(axil_raddr_o),
        .axil_rdata_i(axil_rdata_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // vga_top stand-in: applies strobes to its memory and drives read data only in the
    // one cycle it is due, random garbage otherwise.
    always @(negedge clk_i) begin
        if (axil_wready_o) begin
            st_q.push_back('{cyc, axil_waddr_o, axil_wdata_o, axil_wstrb_o});
            vmem[int'(axil_waddr_o)] = merge(vmem.exists(int'(axil_waddr_o)) ? vmem[int'(axil_waddr_o)] : 32'h0,
                                             axil_wdata_o, axil_wstrb_o);
        end
        if (rd_cnt > 0) begin
            rd_cnt = rd_cnt - 1;
            axil_rdata_i = (rd_cnt == 0) ? (vmem.exists(int'(rd_a)) ? vmem[int'(rd_a)] : 32'h0) : $urandom;
        end else begin
            axil_rdata_i = $urandom;
        end
        if (axil_rreq_o) begin
            rq_q.push_back('{cyc, axil_raddr_o});
            rd_cnt = RD_LAT;
            rd_a = axil_raddr_o;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [16:0] a);
        return mm.exists(int'(a[16:2])) ? mm[int'(a[16:2])] : 32'h0;
    endfunction

    task automatic model_wr(input logic [16:0] a, input logic [31:0] d, input logic [3:0] s);
        mm[int'(a[16:2])] = merge(model_rd(a), d, s);
    endtask

    task automatic do_write(input logic [16:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input int b_dly);
        int aw_c, w_c, hs, t, n0;
        aw_c = -1; w_c = -1; t = 0; n0 = st_q.size();
        while ((aw_c < 0 || w_c < 0) && t < 50) begin
            @(negedge clk_i);
            if (w_c >= 0) chk("wready_drop", ax.wready, 0);
            if (aw_c >= 0) chk("awready_drop", ax.awready, 0);
            ax.awvalid = aw_c < 0 && t >= aw_dly;
            ax.awaddr = a;
            ax.wvalid = w_c < 0 && t >= w_dly;
            ax.wdata = d;
            ax.wstrb = s;
            if (ax.awvalid && ax.awready) aw_c = cyc;
            if (ax.wvalid && ax.wready) w_c = cyc;
            t++;
        end
        hs = aw_c > w_c ? aw_c : w_c;
        @(negedge clk_i);
        ax.awvalid = 1'b0;
        ax.wvalid = 1'b0;
        t = 0;
        while (!ax.bvalid && t < 20) begin
            @(negedge clk_i);
            t++;
        end
        chk("bvalid_lat", cyc, hs + 2);
        chk("bresp", ax.bresp, 0);
        for (int i = 0; i < b_dly; i++) begin
            chk("b_hold", {ax.bvalid, ax.awready, ax.wready}, 3'b100);
            @(negedge clk_i);
        end
        ax.bready = 1'b1;
        @(negedge clk_i);
        ax.bready = 1'b0;
        chk("b_done", {ax.bvalid, ax.awready, ax.wready}, 3'b011);
        chk("strobe_cnt", st_q.size(), n0 + 1);
        if (st_q.size() > n0) begin
            chk("strobe_cyc", st_q[n0].c, hs + 1);
            chk("strobe_addr", st_q[n0].a, a[16:2]);
            chk("strobe_data", st_q[n0].d, d);
            chk("strobe_strb", st_q[n0].s, s);
        end
        model_wr(a, d, s);
    endtask

    task automatic do_read(input logic [16:0] a, input int ar_dly, input int r_dly);
        int ar_c, t, n0;
        logic [31:0] exp;
        ar_c = -1; t = 0; n0 = rq_q.size();
        exp = model_rd(a);
        while (ar_c < 0 && t < 50) begin
            @(negedge clk_i);
            ax.arvalid = t >= ar_dly;
            ax.araddr = a;
            if (ax.arvalid && ax.arready) ar_c = cyc;
            t++;
        end
        @(negedge clk_i);
        ax.arvalid = 1'b0;
        chk("arready_drop", ax.arready, 0);
        t = 0;
        while (!ax.rvalid && t < 20) begin
            @(negedge clk_i);
            t++;
        end
        chk("rvalid_lat", cyc, ar_c + 2 + RD_LAT);
        chk("rdata", ax.rdata, exp);
        chk("rresp", ax.rresp, 0);
        for (int i = 0; i < r_dly; i++) begin
            @(negedge clk_i);
            chk("r_hold", {ax.rvalid, ax.arready, ax.rdata}, {2'b10, exp});
        end
        ax.rready = 1'b1;
        @(negedge clk_i);
        ax.rready = 1'b0;
        chk("r_done", {ax.rvalid, ax.arready}, 2'b01);
        chk("rreq_cnt", rq_q.size(), n0 + 1);
        if (rq_q.size() > n0) begin
            chk("rreq_cyc", rq_q[n0].c, ar_c + 1);
            chk("rreq_addr", rq_q[n0].a, a[16:2]);
        end
    endtask

    initial begin
        int c0, b_c, r_c, n_st, n_rq;
        logic [31:0] r_d;
        logic [16:0] a;
        rstn_i = 1'b0;
        ax.awvalid = 1'b0; ax.awaddr = '0; ax.wvalid = 1'b0; ax.wdata = '0; ax.wstrb = '0;
        ax.bready = 1'b0; ax.arvalid = 1'b0; ax.araddr = '0; ax.rready = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("rst_ctrl", {ax.awready, ax.wready, ax.bvalid, ax.arready, ax.rvalid, axil_wready_o, axil_rreq_o}, 7'd0);
        chk("rst_data", |{ax.rdata, axil_wdata_o, axil_wstrb_o, axil_waddr_o, axil_raddr_o}, 1'b0);
        rstn_i = 1'b1;
        @(negedge clk_i);
        chk("ready_after_rst", {ax.awready, ax.wready, ax.arready}, 3'b111);

        do_write(17'h10000, 32'h41, 4'b0001, 0, 0, 0);
        do_write(17'h1257C, 32'h43, 4'b0001, 2, 0, 0);
        do_write(17'h00020, 32'hCAFE_F00D, 4'b1010, 0, 1, 5);
        do_write(17'h00024, 32'h1111_2222, 4'b0000, 1, 0, 0);
        do_write(17'h08004, 32'h0000_000F, 4'b1111, 0, 0, 0);
        do_read(17'h08004, 0, 3);
        do_read(17'h1257C, 1, 0);

        // simultaneous write and read
        n_st = st_q.size(); n_rq = rq_q.size();
        @(negedge clk_i);
        chk("idle_readies", {ax.awready, ax.wready, ax.arready}, 3'b111);
        ax.awvalid = 1'b1; ax.awaddr = 17'h04000; ax.wvalid = 1'b1; ax.wdata = 32'hAABB_CCDD; ax.wstrb = 4'hF;
        ax.arvalid = 1'b1; ax.araddr = 17'h10000;
        c0 = cyc;
        @(negedge clk_i);
        ax.awvalid = 1'b0; ax.wvalid = 1'b0; ax.arvalid = 1'b0; ax.bready = 1'b1; ax.rready = 1'b1;
        chk("same_cycle", {axil_wready_o, axil_rreq_o}, 2'b11);
        b_c = -1; r_c = -1; r_d = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            if (ax.bvalid) b_c = cyc;
            if (ax.rvalid) begin r_c = cyc; r_d = ax.rdata; end
        end
        ax.bready = 1'b0; ax.rready = 1'b0;
        chk("cc_b_cyc", b_c, c0 + 2);
        chk("cc_r_cyc", r_c, c0 + 2 + RD_LAT);
        chk("cc_rdata", r_d, model_rd(17'h10000));
        chk("cc_strobes", {st_q.size(), rq_q.size()}, {n_st + 1, n_rq + 1});
        model_wr(17'h04000, 32'hAABB_CCDD, 4'hF);
        chk("cc_idle", {ax.awready, ax.wready, ax.arready}, 3'b111);

        // reset while write waits in response and read waits for data
        @(negedge clk_i);
        ax.awvalid = 1'b1; ax.awaddr = 17'h00040; ax.wvalid = 1'b1; ax.wdata = 32'h1234_5678; ax.wstrb = 4'hF;
        @(negedge clk_i);
        ax.awvalid = 1'b0; ax.wvalid = 1'b0; ax.arvalid = 1'b1; ax.araddr = 17'h00040;
        @(negedge clk_i);
        ax.arvalid = 1'b0;
        @(negedge clk_i);
        chk("pre_rst", {ax.bvalid, ax.rvalid}, 2'b10);
        n_rq = rq_q.size();
        rstn_i = 1'b0;
        #1;
        chk("mid_rst_ctrl", {ax.awready, ax.wready, ax.bvalid, ax.arready, ax.rvalid, axil_wready_o, axil_rreq_o}, 7'd0);
        chk("mid_rst_data", |{ax.rdata, axil_wdata_o, axil_wstrb_o, axil_waddr_o, axil_raddr_o}, 1'b0);
        model_wr(17'h00040, 32'h1234_5678, 4'hF);
        repeat (2) @(negedge clk_i);
        rstn_i = 1'b1;
        @(negedge clk_i);
        chk("post_rst", {ax.awready, ax.wready, ax.arready, ax.bvalid, ax.rvalid}, 5'b11100);
        do_write(17'h00044, 32'h5A5A_A5A5, 4'b0110, 0, 0, 1);
        do_read(17'h00044, 0, 0);
        chk("no_extra_rreq", rq_q.size(), n_rq + 1);

        for (int i = 0; i < 40; i++) begin
            a = {2'($urandom_range(0, 2)), 10'd0, 3'($urandom_range(0, 7)), 2'($urandom)};
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            else
                do_read(a, $urandom_range(0, 2), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
